csa_resolve_32: RTL
===================

# csa_resolve_32

Pipelined carry-propagate resolver that converts a 32-bit carry-save pair (sum, carry) into a binary word, result = sum + (carry << 1) mod 2^32. It is the consuming end of the 3:2 carry-save compressors in the hash datapath: compressor trees stay in redundant form across additions and pass through this block once, where a binary value is required (round-state update, digest output). The carry chain is split into SLICE_W-bit slices, one per pipeline stage, behind a valid/ready handshake with full backpressure.

## Interface
- SLICE_W, 8, bits resolved per stage; must divide 32 (legal: 4, 8, 16, 32)
- TAG_W, 4, width of the sideband tag carried alongside each word
- clk  input  1  clock, all state updates on rising edge
- reset_n  input  1  asynchronous active-low reset
- in_valid  input  1  input word present
- in_ready  output  1  block can accept the input word this cycle
- in_sum  input  32  carry-save sum vector (weight 2^i)
- in_carry  input  32  carry-save carry vector (weight 2^(i+1))
- in_tag  input  TAG_W  opaque sideband, returned unchanged with the result
- out_valid  output  1  result present
- out_ready  input  1  downstream accepts the result
- out_data  output  32  resolved binary word
- out_tag  output  TAG_W  tag of the word on out_data
- out_ovf  output  1  only when CSA_RESOLVE_OVF_EN is defined; see Configuration

## Operation
- NS = 32/SLICE_W stages. Operand B = {in_carry[30:0], 1'b0}; in_carry[31] has weight 2^32 and does not contribute to out_data.
- Stage k (0..NS-1) adds slice k of sum and B plus the carry-in registered by stage k-1 (0 for stage 0), producing result slice k and carry-out. Each stage register holds: valid bit, result slices 0..k, unresolved operand slices k+1..NS-1, carry-out, tag (and overflow state when enabled).
- Handshake per stage: rdy[NS] = out_ready; rdy[k] = !v[k] || rdy[k+1]; in_ready = rdy[0]. Stage k loads from stage k-1 (or the input) when rdy[k]; v[k] takes upstream valid. Bubbles collapse; no word is dropped or duplicated; order is preserved.
- Transfer occurs on a cycle with in_valid && in_ready (input) or out_valid && out_ready (output). in_* must be held stable while in_valid && !in_ready.
- out_valid = v[NS-1]; out_data/out_tag are driven directly from the last stage register.
- Full: all NS stages valid and out_ready low -> in_ready low the same cycle. Simultaneous output pop and input push when full is allowed (rdy chain is combinational from out_ready).
- Reset (any time, including mid-stream): all valid bits cleared asynchronously; in-flight words are discarded. Reset values: out_valid 0, out_data 0, out_tag 0, out_ovf 0; in_ready is 1 while reset_n is high and the pipeline is empty.

## Timing
- Latency: NS cycles from input transfer to out_valid (4 for SLICE_W=8); SLICE_W=32 gives 1 cycle.
- Throughput: one word per cycle when out_ready is held high.
- Combinational paths: out_ready -> in_ready (ready chain, NS gates deep); no path from in_* to out_*.
- Critical path per stage: one SLICE_W-bit add with carry-in.

## Configuration
- CSA_RESOLVE_OVF_EN defined: out_ovf port exists; out_ovf = 1 when the true value sum + 2*carry is >= 2^32, i.e. in_carry[31] OR carry-out of the top slice; the flag travels with its word, and its reset value is 0.
- Not defined: port and overflow state are absent; the upper bits are discarded silently (mod 2^32).

## Structure
- Shared hash package: word width constant (32), legal SLICE_W check, tag typedef.
- One sub-module, csa_resolve_slice: a single pipeline stage (SLICE_W adder, valid/ready, register), instantiated NS times via generate.

## Test plan
- in_sum=0x000000FF, in_carry=0x00000001, tag=3 -> out_data=0x00000101, tag 3, out_valid exactly 4 cycles after acceptance (SLICE_W=8).
- Ripple across slices: in_sum=0x00FFFFFE, in_carry=0x00000001 -> out_data=0x01000000.
- Wrap: in_sum=0xFFFFFFFF, in_carry=0x80000001 -> out_data=0x00000001; out_ovf=1 with the macro, port absent without it.
- Backpressure: 8 back-to-back words, out_ready low for 4 cycles mid-stream -> in_ready drops once 4 stages are full, all 8 results delivered in order with no duplication.
- Reset mid-stream: reset_n pulsed low with 3 words in flight -> out_valid 0 immediately; after release, first output is the first word accepted post-reset.
- Random: a, b, c random, feed (a^b^c, maj(a,b,c)) -> out_data == (a+b+c) mod 2^32 for 10k words with random in_valid/out_ready, all SLICE_W values.

Source files
------------

// File: rtl/csa_resolve_pkg.sv
// Shared constants and types for the carry-save resolver.
// Word width, legal slice widths and the default tag type.
package csa_resolve_pkg;

  localparam int WORD_W    = 32;
  localparam int TAG_W_DEF = 4;

  typedef logic [TAG_W_DEF-1:0] tag_t;

  function automatic bit slice_w_ok(input int w);
    return (w == 4) || (w == 8) ||
           (w == 16) || (w == 32);
  endfunction

endpackage

// File: rtl/csa_resolve_slice.sv
// One resolver pipeline stage: adds slice IDX with the
// incoming carry and hands the partial word downstream.
module csa_resolve_slice
  import csa_resolve_pkg::*;
#(
  parameter int SLICE_W = 8,
  parameter int IDX     = 0,
  parameter int SB_W    = 4
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              up_valid,
  input  logic [WORD_W-1:0] up_a,
  input  logic [WORD_W-1:0] up_b,
  input  logic              up_c,
  input  logic [SB_W-1:0]   up_sb,
  input  logic              dn_ready,
  output logic              v,
  output logic [WORD_W-1:0] a,
  output logic [WORD_W-1:0] b,
  output logic              c,
  output logic [SB_W-1:0]   sb
);

  localparam int LO = IDX * SLICE_W;

  logic [SLICE_W:0]   add;
  logic [WORD_W-1:0]  a_nxt;
  logic               ld;

  assign add = {1'b0, up_a[LO +: SLICE_W]}
             + {1'b0, up_b[LO +: SLICE_W]}
             + {{SLICE_W{1'b0}}, up_c};

  assign ld = !v || dn_ready;

  // Splice the resolved slice into the partially resolved word.
  always_comb begin
    a_nxt = up_a;
    a_nxt[LO +: SLICE_W] = add[SLICE_W-1:0];
  end

  // Stage register; bubbles collapse because an empty stage always loads.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      v  <= 1'b0;
      a  <= '0;
      b  <= '0;
      c  <= 1'b0;
      sb <= '0;
    end else if (ld) begin
      v  <= up_valid;
      a  <= a_nxt;
      b  <= up_b;
      c  <= add[SLICE_W];
      sb <= up_sb;
    end
  end

endmodule

// File: rtl/csa_resolve_32.sv
// Pipelined carry-save to binary resolver, one slice per stage.
// Optional overflow flag output enabled by CSA_RESOLVE_OVF_EN.
module csa_resolve_32
  import csa_resolve_pkg::*;
#(
  parameter int SLICE_W = 8,
  parameter int TAG_W   = 4
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [WORD_W-1:0] in_sum,
  input  logic [WORD_W-1:0] in_carry,
  input  logic [TAG_W-1:0]  in_tag,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [WORD_W-1:0] out_data,
`ifdef CSA_RESOLVE_OVF_EN
  output logic [TAG_W-1:0]  out_tag,
  output logic              out_ovf
`else
  output logic [TAG_W-1:0]  out_tag
`endif
);

  localparam int NS = WORD_W / SLICE_W;

`ifdef CSA_RESOLVE_OVF_EN
  localparam int SB_W = TAG_W + 1;
`else
  localparam int SB_W = TAG_W;
`endif

  if (!slice_w_ok(SLICE_W)) begin : g_bad_slice_w
    $error("csa_resolve_32: SLICE_W must be 4, 8, 16 or 32");
  end

  logic [SB_W-1:0]   in_sb;
  logic [WORD_W-1:0] in_b;

  logic              v_w  [NS];
  logic [WORD_W-1:0] a_w  [NS];
  logic [WORD_W-1:0] b_w  [NS];
  logic              c_w  [NS];
  logic [SB_W-1:0]   sb_w [NS];
  logic [NS:0]       rdy;
  logic              tail_full;

  assign in_b = {in_carry[WORD_W-2:0], 1'b0};

`ifdef CSA_RESOLVE_OVF_EN
  assign in_sb = {in_carry[WORD_W-1], in_tag};
`else
  logic unused_carry_msb;
  assign in_sb = in_tag;
  assign unused_carry_msb = in_carry[WORD_W-1];
`endif

  // Ready chain, flattened: stage k can load unless it and every
  // stage after it is full while the sink stalls.
  always_comb begin
    rdy       = '0;
    tail_full = 1'b1;
    rdy[NS]   = out_ready;
    for (int k = 0; k < NS; k++) begin
      tail_full = 1'b1;
      for (int j = k; j < NS; j++) begin
        tail_full = tail_full & v_w[j];
      end
      rdy[k] = out_ready | ~tail_full;
    end
  end

  assign in_ready = rdy[0];

  for (genvar k = 0; k < NS; k++) begin : g_stage
    if (k == 0) begin : g_first
      csa_resolve_slice #(
        .SLICE_W (SLICE_W),
        .IDX     (k),
        .SB_W    (SB_W)
      ) u_slice (
        .clk      (clk),
        .reset_n  (reset_n),
        .up_valid (in_valid),
        .up_a     (in_sum),
        .up_b     (in_b),
        .up_c     (1'b0),
        .up_sb    (in_sb),
        .dn_ready (rdy[k+1]),
        .v        (v_w[k]),
        .a        (a_w[k]),
        .b        (b_w[k]),
        .c        (c_w[k]),
        .sb       (sb_w[k])
      );
    end else begin : g_next
      csa_resolve_slice #(
        .SLICE_W (SLICE_W),
        .IDX     (k),
        .SB_W    (SB_W)
      ) u_slice (
        .clk      (clk),
        .reset_n  (reset_n),
        .up_valid (v_w[k-1]),
        .up_a     (a_w[k-1]),
        .up_b     (b_w[k-1]),
        .up_c     (c_w[k-1]),
        .up_sb    (sb_w[k-1]),
        .dn_ready (rdy[k+1]),
        .v        (v_w[k]),
        .a        (a_w[k]),
        .b        (b_w[k]),
        .c        (c_w[k]),
        .sb       (sb_w[k])
      );
    end
  end

  assign out_valid = v_w[NS-1];
  assign out_data  = a_w[NS-1];
  assign out_tag   = sb_w[NS-1][TAG_W-1:0];

`ifdef CSA_RESOLVE_OVF_EN
  logic [WORD_W-1:0] unused_tail;
  assign out_ovf     = sb_w[NS-1][TAG_W] | c_w[NS-1];
  assign unused_tail = b_w[NS-1];
`else
  logic [WORD_W:0] unused_tail;
  assign unused_tail = {b_w[NS-1], c_w[NS-1]};
`endif

endmodule
